// File: rtl/lab7_2_irq_ctrl.sv
// lab7_2_irq_ctrl: interrupt aggregator for Avalon peripherals.
// Level irq lines latch into sticky pending bits. A mask gates which
// pending sources reach the CPU. The lowest pending, unmasked index is
// reported through HIGHEST, and a single registered irq goes to the CPU.
// Optional feature macro: IRQ_EDGE_EN adds per-source rising-edge
// detection (EDGE_SEL register plus irq_prev flops).
module lab7_2_irq_ctrl #(
  parameter int NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic               read_n,
  input  logic [15:0]        writedata,
  input  logic [NUM_SRC-1:0] irq_in,
  output logic [15:0]        readdata,
  output logic               irq_out
);

  localparam logic [2:0] ADDR_PENDING  = 3'd0;
  localparam logic [2:0] ADDR_MASK     = 3'd1;
  localparam logic [2:0] ADDR_RAW      = 3'd2;
  localparam logic [2:0] ADDR_HIGHEST  = 3'd3;
  localparam logic [2:0] ADDR_ACK      = 3'd4;
  localparam logic [2:0] ADDR_EDGE_SEL = 3'd5;

  // Lowest set bit wins. Scanning from the top keeps the last hit, which is
  // the smallest index.
  function automatic logic [3:0] prio_idx(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) begin
        idx = 4'(i);
      end
    end
    return idx;
  endfunction

  logic [NUM_SRC-1:0] pending_r;
  logic [NUM_SRC-1:0] mask_r;
  logic [NUM_SRC-1:0] set_s;
  logic [NUM_SRC-1:0] clr_s;
  logic [NUM_SRC-1:0] pending_nxt_s;
  logic [15:0]        pend16_s;
  logic [15:0]        mask16_s;
  logic [15:0]        raw16_s;
  logic [15:0]        edge16_s;
  logic [15:0]        active16_s;
  logic [15:0]        rd_mux_s;
  logic               wr_s;
  logic               valid_s;
  logic [3:0]         high_idx_s;
  logic               unused_s;

  // read_n has no effect on the data path; the upper writedata bits are
  // don't-care for narrow registers.
  assign unused_s = ^{read_n, writedata};

  assign wr_s = chipselect & ~write_n;

`ifdef IRQ_EDGE_EN
  logic [NUM_SRC-1:0] edge_sel_r;
  logic [NUM_SRC-1:0] irq_prev_r;

  // Edge-select register and previous-sample flops for rising-edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_sel_r <= {NUM_SRC{1'b0}};
      irq_prev_r <= {NUM_SRC{1'b0}};
    end else begin
      irq_prev_r <= irq_in;
      if (wr_s && (address == ADDR_EDGE_SEL)) begin
        edge_sel_r <= writedata[NUM_SRC-1:0];
      end else begin
        edge_sel_r <= edge_sel_r;
      end
    end
  end

  // Per-source set condition: an edge-selected source sets only on a rising
  // edge; any other source sets on its level.
  always_comb begin
    set_s = (irq_in & ~irq_prev_r & edge_sel_r) | (irq_in & ~edge_sel_r);
  end
`else
  // Every source is level-sensitive.
  always_comb begin
    set_s = irq_in;
  end
`endif

  // Clear vector from a write-1-to-clear on PENDING or from an ACK index.
  // An ACK index at or beyond NUM_SRC matches no bit, so it is ignored.
  always_comb begin
    clr_s = {NUM_SRC{1'b0}};
    if (wr_s) begin
      case (address)
        ADDR_PENDING: clr_s = writedata[NUM_SRC-1:0];
        ADDR_ACK: begin
          for (int i = 0; i < NUM_SRC; i++) begin
            if (writedata[3:0] == 4'(i)) begin
              clr_s[i] = 1'b1;
            end else begin
              clr_s[i] = 1'b0;
            end
          end
        end
        default: clr_s = {NUM_SRC{1'b0}};
      endcase
    end else begin
      clr_s = {NUM_SRC{1'b0}};
    end
  end

  // Set is applied after clear, so a still-asserted source stays pending.
  always_comb begin
    pending_nxt_s = (pending_r & ~clr_s) | set_s;
  end

  // Pending and mask state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_r <= {NUM_SRC{1'b0}};
      mask_r    <= {NUM_SRC{1'b0}};
    end else begin
      pending_r <= pending_nxt_s;
      if (wr_s && (address == ADDR_MASK)) begin
        mask_r <= writedata[NUM_SRC-1:0];
      end else begin
        mask_r <= mask_r;
      end
    end
  end

  // Zero-extend the NUM_SRC-wide vectors to the 16-bit register view.
  always_comb begin
    pend16_s = 16'h0000;
    mask16_s = 16'h0000;
    raw16_s  = 16'h0000;
    edge16_s = 16'h0000;
    for (int i = 0; i < NUM_SRC; i++) begin
      pend16_s[i] = pending_r[i];
      mask16_s[i] = mask_r[i];
      raw16_s[i]  = irq_in[i];
`ifdef IRQ_EDGE_EN
      edge16_s[i] = edge_sel_r[i];
`else
      edge16_s[i] = 1'b0;
`endif
    end
  end

  // Report the highest-priority unmasked pending source. The index is 0 when
  // nothing is active.
  always_comb begin
    active16_s = pend16_s & mask16_s;
    valid_s    = |active16_s;
    if (valid_s) begin
      high_idx_s = prio_idx(active16_s);
    end else begin
      high_idx_s = 4'd0;
    end
  end

  // Read multiplexer.
  always_comb begin
    rd_mux_s = 16'h0000;
    case (address)
      ADDR_PENDING:  rd_mux_s = pend16_s;
      ADDR_MASK:     rd_mux_s = mask16_s;
      ADDR_RAW:      rd_mux_s = raw16_s;
      ADDR_HIGHEST:  rd_mux_s = {valid_s, 11'b000_0000_0000, high_idx_s};
      ADDR_EDGE_SEL: rd_mux_s = edge16_s;
      default:       rd_mux_s = 16'h0000;
    endcase
  end

  // Registered outputs: read data every cycle, and the CPU irq from the
  // current pending and mask.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= 16'h0000;
      irq_out  <= 1'b0;
    end else begin
      readdata <= rd_mux_s;
      irq_out  <= |(pending_r & mask_r);
    end
  end

endmodule

// File: tb/tb_lab7_2_irq_ctrl.sv
// Directed testbench for lab7_2_irq_ctrl (NUM_SRC = 8).
// Define IRQ_EDGE_EN for both files to exercise the edge-select feature.
`timescale 1ns/1ps
module tb_lab7_2_irq_ctrl;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read_n;
  logic [15:0] writedata;
  logic [7:0]  irq_in;
  logic [15:0] readdata;
  logic        irq_out;

  int nvec;
  int nerr;
  logic [15:0] rd;

  lab7_2_irq_ctrl #(.NUM_SRC(8)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata),
    .irq_in(irq_in), .readdata(readdata), .irq_out(irq_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write: present on a negedge; the register updates on the next posedge.
  // The task returns on the following negedge.
  task automatic write_reg(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = 16'h0000;
  endtask

  // Read: present on a negedge; readdata is captured on the posedge and
  // sampled on the next negedge.
  task automatic read_reg(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    chipselect = 1'b1; read_n = 1'b0; address = a;
    @(negedge clk);
    d = readdata;
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  // Hold one bit of irq_in high for one cycle, then drop it.
  task automatic pulse_irq(input logic [7:0] v);
    @(negedge clk);
    irq_in = v;
    @(negedge clk);
    irq_in = 8'h00;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    nvec++;
    if (readdata !== 16'h0000) begin
      nerr++; $display("FAIL reset_readdata got %h exp %h", readdata, 16'h0000);
    end
    nvec++;
    if (irq_out !== 1'b0) begin
      nerr++; $display("FAIL reset_irq_out got %b exp %b", irq_out, 1'b0);
    end
    reset_n = 1'b1;
    read_reg(3'd1, rd);
    nvec++;
    if (rd !== 16'h0000) begin
      nerr++; $display("FAIL reset_mask got %h exp %h", rd, 16'h0000);
    end
    read_reg(3'd3, rd);
    nvec++;
    if (rd !== 16'h0000) begin
      nerr++; $display("FAIL reset_highest got %h exp %h", rd, 16'h0000);
    end
  endtask

  task automatic test_pulse_clear;
    write_reg(3'd1, 16'h0001);
    @(negedge clk);
    irq_in = 8'h01;
    @(negedge clk);            // pending set at this posedge
    irq_in = 8'h00;
    nvec++;
    if (irq_out !== 1'b0) begin
      nerr++; $display("FAIL pulse_irq_early got %b exp %b", irq_out, 1'b0);
    end
    @(negedge clk);
    nvec++;
    if (irq_out !== 1'b1) begin
      nerr++; $display("FAIL pulse_irq_out got %b exp %b", irq_out, 1'b1);
    end
    read_reg(3'd0, rd);
    nvec++;
    if (rd !== 16'h0001) begin
      nerr++; $display("FAIL pulse_pending got %h exp %h", rd, 16'h0001);
    end
    write_reg(3'd0, 16'h0001);
    nvec++;
    if (irq_out !== 1'b1) begin
      nerr++; $display("FAIL clear_irq_1clk got %b exp %b", irq_out, 1'b1);
    end
    @(negedge clk);
    nvec++;
    if (irq_out !== 1'b0) begin
      nerr++; $display("FAIL clear_irq_2clk got %b exp %b", irq_out, 1'b0);
    end
  endtask

  task automatic test_priority_set_wins;
    write_reg(3'd1, 16'h00FF);
    @(negedge clk);
    irq_in = 8'h24;
    read_reg(3'd3, rd);
    nvec++;
    if (rd !== 16'h8002) begin
      nerr++; $display("FAIL highest_0x24 got %h exp %h", rd, 16'h8002);
    end
    read_reg(3'd2, rd);
    nvec++;
    if (rd !== 16'h0024) begin
      nerr++; $display("FAIL raw_0x24 got %h exp %h", rd, 16'h0024);
    end
    write_reg(3'd0, 16'h0004);
    read_reg(3'd0, rd);
    nvec++;
    if (rd !== 16'h0024) begin
      nerr++; $display("FAIL set_wins got %h exp %h", rd, 16'h0024);
    end
    irq_in = 8'h00;
    write_reg(3'd0, 16'h0024);
    read_reg(3'd0, rd);
    nvec++;
    if (rd !== 16'h0000) begin
      nerr++; $display("FAIL clear_after_drop got %h exp %h", rd, 16'h0000);
    end
    // Mask hides the low source: only source 7 is eligible.
    write_reg(3'd1, 16'h0080);
    pulse_irq(8'h81);
    read_reg(3'd3, rd);
    nvec++;
    if (rd !== 16'h8007) begin
      nerr++; $display("FAIL highest_masked got %h exp %h", rd, 16'h8007);
    end
    write_reg(3'd0, 16'h00FF);
  endtask

  task automatic test_masked_latch;
    write_reg(3'd1, 16'h0000);
    pulse_irq(8'h08);
    read_reg(3'd0, rd);
    nvec++;
    if (rd !== 16'h0008) begin
      nerr++; $display("FAIL masked_pending got %h exp %h", rd, 16'h0008);
    end
    nvec++;
    if (irq_out !== 1'b0) begin
      nerr++; $display("FAIL masked_irq_out got %b exp %b", irq_out, 1'b0);
    end
    read_reg(3'd3, rd);
    nvec++;
    if (rd !== 16'h0000) begin
      nerr++; $display("FAIL masked_highest got %h exp %h", rd, 16'h0000);
    end
    write_reg(3'd1, 16'h0008);
    @(negedge clk);
    nvec++;
    if (irq_out !== 1'b1) begin
      nerr++; $display("FAIL unmask_irq_out got %b exp %b", irq_out, 1'b1);
    end
    read_reg(3'd3, rd);
    nvec++;
    if (rd !== 16'h8003) begin
      nerr++; $display("FAIL unmask_highest got %h exp %h", rd, 16'h8003);
    end
    write_reg(3'd0, 16'h0008);
  endtask

  task automatic test_ack;
    pulse_irq(8'h20);
    write_reg(3'd4, 16'h0009);
    read_reg(3'd0, rd);
    nvec++;
    if (rd !== 16'h0020) begin
      nerr++; $display("FAIL ack_idx9 got %h exp %h", rd, 16'h0020);
    end
    write_reg(3'd4, 16'h0005);
    read_reg(3'd0, rd);
    nvec++;
    if (rd !== 16'h0000) begin
      nerr++; $display("FAIL ack_idx5 got %h exp %h", rd, 16'h0000);
    end
    read_reg(3'd6, rd);
    nvec++;
    if (rd !== 16'h0000) begin
      nerr++; $display("FAIL addr6 got %h exp %h", rd, 16'h0000);
    end
  endtask

  task automatic test_edge_sel;
`ifdef IRQ_EDGE_EN
    write_reg(3'd5, 16'h0001);
    read_reg(3'd5, rd);
    nvec++;
    if (rd !== 16'h0001) begin
      nerr++; $display("FAIL edge_sel_rd got %h exp %h", rd, 16'h0001);
    end
    @(negedge clk);
    irq_in = 8'h01;
    @(negedge clk);
    write_reg(3'd0, 16'h0001);
    read_reg(3'd0, rd);
    nvec++;
    if (rd !== 16'h0000) begin
      nerr++; $display("FAIL edge_clear_sticks got %h exp %h", rd, 16'h0000);
    end
    irq_in = 8'h00;
    @(negedge clk);
    irq_in = 8'h01;
    @(negedge clk);
    read_reg(3'd0, rd);
    nvec++;
    if (rd !== 16'h0001) begin
      nerr++; $display("FAIL edge_reassert got %h exp %h", rd, 16'h0001);
    end
    irq_in = 8'h00;
    write_reg(3'd0, 16'h0001);
    write_reg(3'd5, 16'h0000);
`else
    write_reg(3'd5, 16'h0001);
    read_reg(3'd5, rd);
    nvec++;
    if (rd !== 16'h0000) begin
      nerr++; $display("FAIL edge_sel_absent got %h exp %h", rd, 16'h0000);
    end
    @(negedge clk);
    irq_in = 8'h01;
    @(negedge clk);
    write_reg(3'd0, 16'h0001);
    read_reg(3'd0, rd);
    nvec++;
    if (rd !== 16'h0001) begin
      nerr++; $display("FAIL level_only got %h exp %h", rd, 16'h0001);
    end
    irq_in = 8'h00;
    write_reg(3'd0, 16'h0001);
`endif
  endtask

  task automatic test_async_reset;
    write_reg(3'd1, 16'h00FF);
    pulse_irq(8'h10);
    @(negedge clk);
    chipselect = 1'b1; read_n = 1'b0; address = 3'd1;
    @(negedge clk);
    nvec++;
    if (readdata !== 16'h00FF) begin
      nerr++; $display("FAIL pre_reset_read got %h exp %h", readdata, 16'h00FF);
    end
    #2 reset_n = 1'b0;
    #1;
    nvec++;
    if (readdata !== 16'h0000) begin
      nerr++; $display("FAIL async_rst_readdata got %h exp %h", readdata, 16'h0000);
    end
    nvec++;
    if (irq_out !== 1'b0) begin
      nerr++; $display("FAIL async_rst_irq got %b exp %b", irq_out, 1'b0);
    end
    chipselect = 1'b0; read_n = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    read_reg(3'd0, rd);
    nvec++;
    if (rd !== 16'h0000) begin
      nerr++; $display("FAIL post_rst_pending got %h exp %h", rd, 16'h0000);
    end
  endtask

  initial begin
    nvec = 0; nerr = 0;
    reset_n = 1'b0; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
    read_n = 1'b1; writedata = 16'h0000; irq_in = 8'h00;
    test_reset();
    test_pulse_clear();
    test_priority_set_wins();
    test_masked_latch();
    test_ack();
    test_edge_sel();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
